// File: rtl/demux_1to4.sv
// Registered 1-to-4 demultiplexer: routes din to the channel picked by sel, one clock later,
// with a per-channel valid flag and a saturating per-channel transfer counter.
module demux_1to4 #(
    parameter int WIDTH = 1,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    input  logic [1:0]       sel,
    input  logic             in_valid,
    input  logic             cnt_clr,
    output logic [WIDTH-1:0] y0,
    output logic [WIDTH-1:0] y1,
    output logic [WIDTH-1:0] y2,
    output logic [WIDTH-1:0] y3,
    output logic [3:0]       y_valid,
    output logic [CNT_W-1:0] cnt0,
    output logic [CNT_W-1:0] cnt1,
    output logic [CNT_W-1:0] cnt2,
    output logic [CNT_W-1:0] cnt3
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [CNT_W-1:0] cnt [4];

    // Data is routed every cycle; in_valid only qualifies y_valid and the counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            y0      <= '0;
            y1      <= '0;
            y2      <= '0;
            y3      <= '0;
            y_valid <= '0;
        end else begin
            y0      <= '0;
            y1      <= '0;
            y2      <= '0;
            y3      <= '0;
            y_valid <= '0;
            case (sel)
                2'b00: begin
                    y0         <= din;
                    y_valid[0] <= in_valid;
                end
                2'b01: begin
                    y1         <= din;
                    y_valid[1] <= in_valid;
                end
                2'b10: begin
                    y2         <= din;
                    y_valid[2] <= in_valid;
                end
                default: begin
                    y3         <= din;
                    y_valid[3] <= in_valid;
                end
            endcase
        end
    end

    // Clear wins over a same-cycle increment; counters stick at CNT_MAX.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 4; i++) cnt[i] <= '0;
        end else if (cnt_clr) begin
            for (int i = 0; i < 4; i++) cnt[i] <= '0;
        end else if (in_valid && (cnt[sel] != CNT_MAX)) begin
            cnt[sel] <= cnt[sel] + 1'b1;
        end
    end

    assign cnt0 = cnt[0];
    assign cnt1 = cnt[1];
    assign cnt2 = cnt[2];
    assign cnt3 = cnt[3];

endmodule

// File: tb/tb_demux_1to4.sv
// Directed bench for demux_1to4: a default-parameter instance and a WIDTH=8/CNT_W=2 instance
// sharing clock, reset and control, checked against hand-computed values.
module tb_demux_1to4;

    logic        clk;
    logic        rst;
    logic        din_n;
    logic [7:0]  din_w;
    logic [1:0]  sel;
    logic        in_valid;
    logic        cnt_clr;

    logic        ny0, ny1, ny2, ny3;
    logic [3:0]  nyv;
    logic [15:0] nc0, nc1, nc2, nc3;

    logic [7:0]  wy0, wy1, wy2, wy3;
    logic [3:0]  wyv;
    logic [1:0]  wc0, wc1, wc2, wc3;

    int n_vec = 0;
    int n_err = 0;

    demux_1to4 u_dut (
        .clk(clk), .rst(rst), .din(din_n), .sel(sel), .in_valid(in_valid), .cnt_clr(cnt_clr),
        .y0(ny0), .y1(ny1), .y2(ny2), .y3(ny3), .y_valid(nyv),
        .cnt0(nc0), .cnt1(nc1), .cnt2(nc2), .cnt3(nc3)
    );

    demux_1to4 #(.WIDTH(8), .CNT_W(2)) u_wide (
        .clk(clk), .rst(rst), .din(din_w), .sel(sel), .in_valid(in_valid), .cnt_clr(cnt_clr),
        .y0(wy0), .y1(wy1), .y2(wy2), .y3(wy3), .y_valid(wyv),
        .cnt0(wc0), .cnt1(wc1), .cnt2(wc2), .cnt3(wc3)
    );

    // clock/reset block
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout, expected finish");
        $fatal(1, "watchdog expired");
    end

    // advance one clock and settle 1 time unit past the edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst = 1'b1; din_n = 1'b0; din_w = 8'h00; sel = 2'b00; in_valid = 1'b0; cnt_clr = 1'b0;
        step();
        step();
        chk("rst_hold_y",    {ny0, ny1, ny2, ny3}, 4'b0000);
        chk("rst_hold_cnt0", nc0, 16'd0);
        rst = 1'b0;

        // one transfer so outputs are nonzero before the mid-cycle reset
        din_n = 1'b1; din_w = 8'h3C; sel = 2'b01; in_valid = 1'b1;
        step();
        chk("pre_rst_y",   {ny0, ny1, ny2, ny3}, 4'b0100);
        chk("pre_rst_cnt1", nc1, 16'd1);
        chk("pre_rst_wy1", wy1, 8'h3C);
        #3 rst = 1'b1;
        #1;
        chk("async_rst_y",   {ny0, ny1, ny2, ny3}, 4'b0000);
        chk("async_rst_yv",  nyv, 4'b0000);
        chk("async_rst_cnt", {nc0, nc1, nc2, nc3}, 64'd0);
        chk("async_rst_wy1", wy1, 8'h00);
        chk("async_rst_wc1", wc1, 2'd0);
        step();
        chk("rst_held_y",  {ny0, ny1, ny2, ny3}, 4'b0000);
        chk("rst_held_yv", nyv, 4'b0000);
        rst = 1'b0;

        // walking one across the four channels
        din_n = 1'b1; din_w = 8'h01; in_valid = 1'b1;
        for (int s = 0; s < 4; s++) begin
            sel = s[1:0];
            step();
            chk($sformatf("sweep_y_%0d", s),  {ny0, ny1, ny2, ny3}, 4'b1000 >> s);
            chk($sformatf("sweep_yv_%0d", s), nyv, 4'b0001 << s);
        end
        chk("sweep_cnt0", nc0, 16'd1);
        chk("sweep_cnt1", nc1, 16'd1);
        chk("sweep_cnt2", nc2, 16'd1);
        chk("sweep_cnt3", nc3, 16'd1);

        // zero data on a valid transfer
        din_n = 1'b0; din_w = 8'h00; sel = 2'b10; in_valid = 1'b1;
        step();
        chk("zero_y",    {ny0, ny1, ny2, ny3}, 4'b0000);
        chk("zero_yv",   nyv, 4'b0100);
        chk("zero_cnt2", nc2, 16'd2);

        // data routed without valid: no flag, no count
        din_n = 1'b1; sel = 2'b11; in_valid = 1'b0;
        step();
        chk("inval_y",    {ny0, ny1, ny2, ny3}, 4'b0001);
        chk("inval_yv",   nyv, 4'b0000);
        chk("inval_cnt3", nc3, 16'd1);

        // wide data
        din_w = 8'hA5; sel = 2'b10; in_valid = 1'b1;
        step();
        chk("wide_y",    {wy0, wy1, wy2, wy3}, 32'h0000A500);
        chk("wide_yv",   wyv, 4'b0100);
        chk("wide_cnt2", nc2, 16'd3);

        // clear alone leaves data paths untouched
        cnt_clr = 1'b1; in_valid = 1'b0;
        step();
        chk("clr_wy2",  wy2, 8'hA5);
        chk("clr_wyv",  wyv, 4'b0000);
        chk("clr_ncnt", {nc0, nc1, nc2, nc3}, 64'd0);
        chk("clr_wcnt", {wc0, wc1, wc2, wc3}, 8'd0);

        // saturation on the 2-bit counters
        cnt_clr = 1'b0; din_w = 8'h11; sel = 2'b01; in_valid = 1'b1;
        step(); chk("sat_1", wc1, 2'd1);
        step(); chk("sat_2", wc1, 2'd2);
        step(); chk("sat_3", wc1, 2'd3);
        step(); chk("sat_4", wc1, 2'd3);
        step(); chk("sat_5", wc1, 2'd3);
        chk("sat_ncnt1", nc1, 16'd5);
        chk("sat_wc0",   wc0, 2'd0);

        // clear beats a simultaneous increment
        cnt_clr = 1'b1;
        step();
        chk("clr_pri_wc1", wc1, 2'd0);
        chk("clr_pri_nc1", nc1, 16'd0);
        chk("clr_pri_wyv", wyv, 4'b0010);
        chk("clr_pri_wy1", wy1, 8'h11);

        cnt_clr = 1'b0; in_valid = 1'b0;
        step();
        chk("post_clr_wc1", wc1, 2'd0);
        chk("post_clr_yv",  wyv, 4'b0000);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
